prbs_burst_controller: RTL and testbench
========================================

Name: prbs_burst_controller

Overview:
- Sequences the PRBS modulator: generates the PRBS bit stream at a programmable bit period and runs it in bursts separated by gaps.
- Shadows the modulator's edge, amplitude and offset configuration so changes take effect only on bit boundaries.
- Sits between the register bank and prbs_modulator. Outputs connect directly to its prbs_bit_in, edge_time_config, amplitude_config and dc_offset_config.

Parameters:
- BP_W, 16, width of the bit-period configuration, in DAC clock cycles.
- BB_W, 24, width of the bits-per-burst configuration and counter.

Ports:
- dac_clk  in  1  main DAC clock; the only clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; starts a sequence when idle.
- stop  in  1  single-cycle pulse; aborts the sequence.
- bit_period_cfg  in  BP_W  DAC cycles per PRBS bit; values 0 and 1 are treated as 2.
- prbs_order_cfg  in  2  0=PRBS7, 1=PRBS9, 2=PRBS15, 3=PRBS23.
- burst_bits_cfg  in  BB_W  bits per burst; 0 = continuous, no bursts.
- burst_count_cfg  in  16  bursts per sequence; 0 = unlimited.
- gap_cycles_cfg  in  16  idle DAC cycles between bursts.
- idle_level_cfg  in  1  bit value driven while not emitting PRBS.
- reseed_per_burst  in  1  1 = reload the LFSR seed at the start of every burst.
- cfg_update  in  1  pulse; requests transfer of the *_in modulator settings to the outputs.
- edge_time_in  in  8  pending edge-time value.
- amplitude_in  in  16  pending amplitude value.
- dc_offset_in  in  16  pending DC offset value.
- prbs_bit_out  out  1  bit driven to the modulator.
- bit_strobe  out  1  high in the first cycle of each emitted bit.
- busy  out  1  high in RUN and GAP.
- burst_active  out  1  high in RUN.
- done  out  1  one-cycle pulse when the final burst completes.
- edge_time_config  out  8  shadowed edge time.
- amplitude_config  out  16  shadowed amplitude.
- dc_offset_config  out  16  shadowed DC offset.

Behaviour:
- Reset values:
  - prbs_bit_out=0, bit_strobe=0, busy=0, burst_active=0, done=0.
  - edge_time_config=8'd4, amplitude_config=16'h4000, dc_offset_config=0.
  - State IDLE, LFSR all-ones.
- States:
  - IDLE: prbs_bit_out=idle_level_cfg. On start (with no stop), latch all sequence configs and seed the LFSR to all-ones; go to RUN next cycle.
  - RUN: the cycle counter runs 0..period-1. bit_strobe and the new prbs_bit_out are both asserted at count 0. The LFSR shifts once per bit.
  - GAP: counts gap_cycles_cfg cycles with prbs_bit_out=idle_level; then go to RUN and emit the first bit on entry.
- Burst end: after the last bit's final cycle, increment the burst counter.
  - Counter equals burst_count_cfg (nonzero): pulse done, go to IDLE.
  - Otherwise: go to GAP if gap>0, else RUN with a back-to-back first bit.
  - burst_bits_cfg=0: RUN never ends except on stop.
- LFSR: 23-bit Fibonacci register; N = selected order.
  - Output = lfsr[N-1].
  - Feedback lfsr[N-1]^lfsr[T-1], shifted into bit 0; taps T = 6, 5, 14, 18 for N = 7, 9, 15, 23.
  - If bits [N-1:0] are all zero, reload all-ones.
- Command priority:
  - stop in any state: go to IDLE next cycle, no done pulse. done is suppressed even if the burst end coincides with stop.
  - start and stop in the same cycle: stop wins.
  - start while busy: ignored.
- Config changes while busy: sequence configs are not re-read until the next start.
- Modulator shadowing:
  - cfg_update captures the *_in values into a pending register and sets pend.
  - Pending values go to the outputs on the next bit_strobe cycle in RUN, or on the next cycle in IDLE/GAP; pend then clears.
  - A second cfg_update before transfer overwrites the pending values.
- Latency: start to first bit_strobe = 1 cycle.

Optional Feature:
- Macro: PRBS_ERR_INJECT_EN.
- Defined: adds input err_inject (pulse) and output err_inject_cnt[15:0].
  - A pulse arms a one-shot that inverts the next emitted bit only; the LFSR state is unaffected.
  - The counter increments per injected bit and saturates at 16'hFFFF.
  - Arming while already armed does not stack. reset_n clears both the one-shot and the counter.
- Undefined: these ports and their logic are absent; the bit stream is pure PRBS.

Test Plan:
1. Order 0, period 4, burst_bits 0, start → bit_strobe every 4 cycles; first 7 bits =1, 8th =0; pattern repeats every 127 bits with 64 ones.
2. burst_bits 10, burst_count 3, gap 20, period 2 → three RUN windows of 20 cycles each, separated by 20-cycle gaps at idle_level; done pulses once, 1 cycle after the last bit ends; busy falls the same cycle.
3. cfg_update with amplitude_in=16'h2000 in mid-bit during RUN → amplitude_config changes exactly on the next bit_strobe cycle, not earlier.
4. stop issued on the burst-end cycle of the final burst → IDLE next cycle, no done; a start in the same cycle as a stop is ignored.
5. bit_period_cfg=0 → treated as 2; reseed_per_burst=1, burst_bits 5 → every burst emits the identical first 5 bits.
6. Assert reset_n low mid-RUN → all outputs return to reset values asynchronously, LFSR reseeds; (PRBS_ERR_INJECT_EN) an err_inject pulse flips exactly one bit and err_inject_cnt=1.

Source files
------------

// File: rtl/prbs_burst_controller.sv
// PRBS bit sequencer with burst/gap framing and bit-aligned shadowing of the
// modulator settings. Define PRBS_ERR_INJECT_EN to add one-shot bit-error injection.
module prbs_burst_controller #(
   parameter int BP_W = 16,
   parameter int BB_W = 24
) (
   input  logic            dac_clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            stop,
   input  logic [BP_W-1:0] bit_period_cfg,
   input  logic [1:0]      prbs_order_cfg,
   input  logic [BB_W-1:0] burst_bits_cfg,
   input  logic [15:0]     burst_count_cfg,
   input  logic [15:0]     gap_cycles_cfg,
   input  logic            idle_level_cfg,
   input  logic            reseed_per_burst,
   input  logic            cfg_update,
   input  logic [7:0]      edge_time_in,
   input  logic [15:0]     amplitude_in,
   input  logic [15:0]     dc_offset_in,
`ifdef PRBS_ERR_INJECT_EN
   input  logic            err_inject,
   output logic [15:0]     err_inject_cnt,
`endif
   output logic            prbs_bit_out,
   output logic            bit_strobe,
   output logic            busy,
   output logic            burst_active,
   output logic            done,
   output logic [7:0]      edge_time_config,
   output logic [15:0]     amplitude_config,
   output logic [15:0]     dc_offset_config
);

   typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
   localparam logic [22:0] SEED = '1;

   state_t          state_reg, state_next;
   logic [BP_W-1:0] cnt_reg, cnt_next, period_reg;
   logic [BB_W-1:0] bit_idx_reg, bit_idx_next, burst_bits_reg;
   logic [15:0]     burst_idx_reg, burst_idx_next, burst_idx_inc, burst_count_reg;
   logic [15:0]     gap_reg, gap_next, gap_cfg_reg;
   logic [1:0]      order_reg, order_sel;
   logic            idle_reg, reseed_reg;
   logic [22:0]     lfsr_reg, lfsr_next, lfsr_src, order_mask;
   logic [4:0]      n_msb, t_msb;
   logic            bit_reg, bit_next, done_reg, done_next;
   logic            cfg_load, emit, new_burst, use_seed, lfsr_bit, lfsr_fb, inject;
   logic            pend_reg, pend_next, xfer;
   logic [7:0]      edge_pend_reg, edge_reg;
   logic [15:0]     amp_pend_reg, amp_reg, off_pend_reg, off_reg;

`ifdef PRBS_ERR_INJECT_EN
   logic        armed_reg;
   logic [15:0] err_cnt_reg;

   // The one-shot only flips the driven bit; the LFSR keeps its true sequence.
   always_ff @(posedge dac_clk or negedge reset_n) begin
      if (!reset_n) begin
         armed_reg   <= 1'b0;
         err_cnt_reg <= '0;
      end else begin
         armed_reg <= err_inject || (armed_reg && !emit);
         if (inject && err_cnt_reg != 16'hFFFF)
            err_cnt_reg <= err_cnt_reg + 16'd1;
      end
   end

   assign inject         = emit && armed_reg;
   assign err_inject_cnt = err_cnt_reg;
`else
   assign inject = 1'b0;
`endif

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      bit_idx_next   = bit_idx_reg;
      burst_idx_next = burst_idx_reg;
      burst_idx_inc  = burst_idx_reg + 16'd1;
      gap_next       = gap_reg;
      done_next      = 1'b0;
      cfg_load       = 1'b0;
      emit           = 1'b0;
      new_burst      = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (start && !stop) begin
               cfg_load       = 1'b1;
               state_next     = RUN;
               emit           = 1'b1;
               new_burst      = 1'b1;
               burst_idx_next = '0;
            end
         end
         RUN: begin
            if (stop) begin
               state_next = IDLE;
            end else if (cnt_reg == period_reg - BP_W'(1)) begin
               if (burst_bits_reg != '0 && bit_idx_reg == burst_bits_reg - BB_W'(1)) begin
                  if (burst_count_reg != '0 && burst_idx_inc == burst_count_reg) begin
                     state_next = IDLE;
                     done_next  = 1'b1;
                  end else begin
                     burst_idx_next = burst_idx_inc;
                     if (gap_cfg_reg != '0) begin
                        state_next = GAP;
                        gap_next   = '0;
                     end else begin
                        emit      = 1'b1;
                        new_burst = 1'b1;
                     end
                  end
               end else begin
                  emit = 1'b1;
               end
            end else begin
               cnt_next = cnt_reg + BP_W'(1);
            end
         end
         GAP: begin
            if (stop) begin
               state_next = IDLE;
            end else if (gap_reg == gap_cfg_reg - 16'd1) begin
               state_next = RUN;
               emit       = 1'b1;
               new_burst  = 1'b1;
            end else begin
               gap_next = gap_reg + 16'd1;
            end
         end
         default: state_next = IDLE;
      endcase

      if (emit) begin
         cnt_next     = '0;
         bit_idx_next = new_burst ? '0 : bit_idx_reg + BB_W'(1);
      end

      // The start cycle must already use the incoming order, not the stale one.
      order_sel = cfg_load ? prbs_order_cfg : order_reg;
      unique case (order_sel)
         2'd0:    begin n_msb = 5'd6;  t_msb = 5'd5;  order_mask = 23'h00007F; end
         2'd1:    begin n_msb = 5'd8;  t_msb = 5'd4;  order_mask = 23'h0001FF; end
         2'd2:    begin n_msb = 5'd14; t_msb = 5'd13; order_mask = 23'h007FFF; end
         default: begin n_msb = 5'd22; t_msb = 5'd17; order_mask = 23'h7FFFFF; end
      endcase
      use_seed = cfg_load || (new_burst && reseed_reg);
      lfsr_src = use_seed ? SEED : lfsr_reg;
      if ((lfsr_src & order_mask) == '0)
         lfsr_src = SEED;
      lfsr_bit  = lfsr_src[n_msb];
      lfsr_fb   = lfsr_src[n_msb] ^ lfsr_src[t_msb];
      lfsr_next = emit ? {lfsr_src[21:0], lfsr_fb} : lfsr_reg;

      if (emit)
         bit_next = lfsr_bit ^ inject;
      else if (state_next == RUN)
         bit_next = bit_reg;
      else if (state_next == GAP)
         bit_next = idle_reg;
      else
         bit_next = idle_level_cfg;

      xfer      = pend_reg && (state_reg != RUN || emit);
      pend_next = cfg_update || (pend_reg && !xfer);
   end

   always_ff @(posedge dac_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         bit_idx_reg     <= '0;
         burst_idx_reg   <= '0;
         gap_reg         <= '0;
         lfsr_reg        <= SEED;
         bit_reg         <= 1'b0;
         done_reg        <= 1'b0;
         period_reg      <= BP_W'(2);
         order_reg       <= '0;
         burst_bits_reg  <= '0;
         burst_count_reg <= '0;
         gap_cfg_reg     <= '0;
         idle_reg        <= 1'b0;
         reseed_reg      <= 1'b0;
         pend_reg        <= 1'b0;
         edge_pend_reg   <= 8'd4;
         amp_pend_reg    <= 16'h4000;
         off_pend_reg    <= '0;
         edge_reg        <= 8'd4;
         amp_reg         <= 16'h4000;
         off_reg         <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         bit_idx_reg   <= bit_idx_next;
         burst_idx_reg <= burst_idx_next;
         gap_reg       <= gap_next;
         lfsr_reg      <= lfsr_next;
         bit_reg       <= bit_next;
         done_reg      <= done_next;
         pend_reg      <= pend_next;
         if (cfg_load) begin
            period_reg      <= (bit_period_cfg < BP_W'(2)) ? BP_W'(2) : bit_period_cfg;
            order_reg       <= prbs_order_cfg;
            burst_bits_reg  <= burst_bits_cfg;
            burst_count_reg <= burst_count_cfg;
            gap_cfg_reg     <= gap_cycles_cfg;
            idle_reg        <= idle_level_cfg;
            reseed_reg      <= reseed_per_burst;
         end
         if (cfg_update) begin
            edge_pend_reg <= edge_time_in;
            amp_pend_reg  <= amplitude_in;
            off_pend_reg  <= dc_offset_in;
         end
         if (xfer) begin
            edge_reg <= edge_pend_reg;
            amp_reg  <= amp_pend_reg;
            off_reg  <= off_pend_reg;
         end
      end
   end

   assign prbs_bit_out     = bit_reg;
   assign bit_strobe       = (state_reg == RUN) && (cnt_reg == '0);
   assign busy             = (state_reg != IDLE);
   assign burst_active     = (state_reg == RUN);
   assign done             = done_reg;
   assign edge_time_config = edge_reg;
   assign amplitude_config = amp_reg;
   assign dc_offset_config = off_reg;

endmodule

// File: tb/tb_prbs_burst_controller.sv
// Self-checking bench for prbs_burst_controller: directed scenarios plus
// randomized sequences against a per-cycle expected trace built from the PRBS recurrence.
module tb_prbs_burst_controller;

   logic        dac_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0, stop = 1'b0;
   logic [15:0] bit_period_cfg = 16'd4;
   logic [1:0]  prbs_order_cfg = 2'd0;
   logic [23:0] burst_bits_cfg = '0;
   logic [15:0] burst_count_cfg = '0, gap_cycles_cfg = '0;
   logic        idle_level_cfg = 1'b1, reseed_per_burst = 1'b0, cfg_update = 1'b0;
   logic [7:0]  edge_time_in = 8'd4;
   logic [15:0] amplitude_in = 16'h4000, dc_offset_in = 16'h0000;
   logic        prbs_bit_out, bit_strobe, busy, burst_active, done;
   logic [7:0]  edge_time_config;
   logic [15:0] amplitude_config, dc_offset_config;
`ifdef PRBS_ERR_INJECT_EN
   logic        err_inject = 1'b0;
   logic [15:0] err_inject_cnt;
`endif

   int checks = 0;
   int errors = 0;
   bit seq_m [0:4095];
   bit q_bit[$], q_stb[$], q_busy[$], q_act[$], q_done[$];

   prbs_burst_controller #(.BP_W(16), .BB_W(24)) dut (
      .dac_clk(dac_clk), .reset_n(reset_n), .start(start), .stop(stop),
      .bit_period_cfg(bit_period_cfg), .prbs_order_cfg(prbs_order_cfg),
      .burst_bits_cfg(burst_bits_cfg), .burst_count_cfg(burst_count_cfg),
      .gap_cycles_cfg(gap_cycles_cfg), .idle_level_cfg(idle_level_cfg),
      .reseed_per_burst(reseed_per_burst), .cfg_update(cfg_update),
      .edge_time_in(edge_time_in), .amplitude_in(amplitude_in), .dc_offset_in(dc_offset_in),
`ifdef PRBS_ERR_INJECT_EN
      .err_inject(err_inject), .err_inject_cnt(err_inject_cnt),
`endif
      .prbs_bit_out(prbs_bit_out), .bit_strobe(bit_strobe), .busy(busy),
      .burst_active(burst_active), .done(done), .edge_time_config(edge_time_config),
      .amplitude_config(amplitude_config), .dc_offset_config(dc_offset_config)
   );

   always #5 dac_clk = ~dac_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output sequence of a Fibonacci LFSR seeded all-ones: o[m] = o[m-N] ^ o[m-T].
   function automatic void gen_seq(input int order);
      int n, t;
      case (order)
         0:       begin n = 7;  t = 6;  end
         1:       begin n = 9;  t = 5;  end
         2:       begin n = 15; t = 14; end
         default: begin n = 23; t = 18; end
      endcase
      for (int m = 0; m < 4096; m++) begin
         if (m < n) seq_m[m] = 1'b1;
         else       seq_m[m] = seq_m[m-n] ^ seq_m[m-t];
      end
   endfunction

   function automatic void push(bit b, bit s, bit bu, bit a, bit d);
      q_bit.push_back(b); q_stb.push_back(s); q_busy.push_back(bu);
      q_act.push_back(a); q_done.push_back(d);
   endfunction

   function automatic void build_trace(int period, int bb, int bc, int gap, bit idl, bit rsd, bit flip);
      int p = (period < 2) ? 2 : period;
      int k = 0;
      int e = 0;
      q_bit.delete(); q_stb.delete(); q_busy.delete(); q_act.delete(); q_done.delete();
      for (int b = 0; b < bc; b++) begin
         if (rsd) k = 0;
         for (int i = 0; i < bb; i++) begin
            for (int c = 0; c < p; c++)
               push(seq_m[k] ^ (flip && e == 0), c == 0, 1'b1, 1'b1, 1'b0);
            k++;
            e++;
         end
         if (b != bc - 1)
            for (int g = 0; g < gap; g++) push(idl, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      push(idl, 1'b0, 1'b0, 1'b0, 1'b1);
   endfunction

   task automatic run_seq(input int order, input int period, input int bb, input int bc,
                          input int gap, input bit idl, input bit rsd, input bit chaos,
                          input bit flip, input bit stop_last);
      int stop_at;
      gen_seq(order);
      build_trace(period, bb, bc, gap, idl, rsd, flip);
      stop_at = stop_last ? q_bit.size() - 2 : -1;
      @(negedge dac_clk);
      bit_period_cfg = 16'(period); prbs_order_cfg = 2'(order);
      burst_bits_cfg = 24'(bb); burst_count_cfg = 16'(bc); gap_cycles_cfg = 16'(gap);
      idle_level_cfg = idl; reseed_per_burst = rsd; start = 1'b1;
      $display("seq order=%0d period=%0d bits=%0d bursts=%0d gap=%0d reseed=%0d stop_last=%0d cycles=%0d",
               order, period, bb, bc, gap, rsd, stop_last, q_bit.size());
      @(posedge dac_clk);
      for (int i = 0; i < q_bit.size(); i++) begin
         @(negedge dac_clk);
         start = 1'b0;
         stop  = 1'b0;
         if (stop_at >= 0 && i > stop_at) begin
            check($sformatf("stop done[%0d]", i), 32'(done), 32'd0);
            check($sformatf("stop busy[%0d]", i), 32'(busy), 32'd0);
            check($sformatf("stop act[%0d]", i), 32'(burst_active), 32'd0);
            check($sformatf("stop bit[%0d]", i), 32'(prbs_bit_out), 32'(idl));
            break;
         end
         check($sformatf("bit[%0d]", i), 32'(prbs_bit_out), 32'(q_bit[i]));
         check($sformatf("strobe[%0d]", i), 32'(bit_strobe), 32'(q_stb[i]));
         check($sformatf("busy[%0d]", i), 32'(busy), 32'(q_busy[i]));
         check($sformatf("active[%0d]", i), 32'(burst_active), 32'(q_act[i]));
         check($sformatf("done[%0d]", i), 32'(done), 32'(q_done[i]));
         if (i == stop_at) stop = 1'b1;
         if (chaos && i + 2 < q_bit.size()) begin
            bit_period_cfg   = 16'($urandom_range(0, 6));
            prbs_order_cfg   = 2'($urandom_range(0, 3));
            burst_bits_cfg   = 24'($urandom_range(0, 9));
            burst_count_cfg  = 16'($urandom_range(0, 4));
            gap_cycles_cfg   = 16'($urandom_range(0, 5));
            reseed_per_burst = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) start = 1'b1;
         end
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " bit"}, 32'(prbs_bit_out), 32'd0);
      check({tag, " strobe"}, 32'(bit_strobe), 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " active"}, 32'(burst_active), 32'd0);
      check({tag, " done"}, 32'(done), 32'd0);
      check({tag, " edge"}, 32'(edge_time_config), 32'h04);
      check({tag, " amp"}, 32'(amplitude_config), 32'h4000);
      check({tag, " off"}, 32'(dc_offset_config), 32'h0);
   endtask

   initial begin
      int ones;
      // reset state
      repeat (2) @(negedge dac_clk);
      check_reset_values("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge dac_clk);
      check("idle level", 32'(prbs_bit_out), 32'(idle_level_cfg));
      check("idle busy", 32'(busy), 32'd0);

      // continuous PRBS7 at period 4
      gen_seq(0);
      @(negedge dac_clk);
      bit_period_cfg = 16'd4; prbs_order_cfg = 2'd0; burst_bits_cfg = '0;
      burst_count_cfg = '0; gap_cycles_cfg = '0; start = 1'b1;
      @(posedge dac_clk);
      ones = 0;
      for (int k = 0; k < 254; k++) begin
         for (int c = 0; c < 4; c++) begin
            @(negedge dac_clk);
            start = 1'b0;
            check($sformatf("cont bit[%0d]", k), 32'(prbs_bit_out), 32'(seq_m[k]));
            check($sformatf("cont strobe[%0d.%0d]", k, c), 32'(bit_strobe), 32'(c == 0));
            if (c == 0 && k < 127) ones = ones + int'(prbs_bit_out);
         end
      end
      check("ones in 127 bits", 32'(ones), 32'd64);
      $display("continuous PRBS7: 254 bits, ones in first period=%0d", ones);
      @(negedge dac_clk);
      stop = 1'b1;
      @(negedge dac_clk);
      stop = 1'b0;
      check("cont stop busy", 32'(busy), 32'd0);
      check("cont stop done", 32'(done), 32'd0);

      // shadow transfer aligned to bit strobes
      @(negedge dac_clk);
      bit_period_cfg = 16'd8; start = 1'b1;
      @(posedge dac_clk);
      for (int i = 0; i < 17; i++) begin
         @(negedge dac_clk);
         start = 1'b0;
         cfg_update = 1'b0;
         check($sformatf("shadow amp[%0d]", i), 32'(amplitude_config),
               (i < 8) ? 32'h4000 : (i < 16) ? 32'h2000 : 32'h3333);
         check($sformatf("shadow strobe[%0d]", i), 32'(bit_strobe), 32'(i % 8 == 0));
         if (i == 3)  begin amplitude_in = 16'h2000; cfg_update = 1'b1; end
         if (i == 10) begin amplitude_in = 16'h1111; cfg_update = 1'b1; end
         if (i == 11) begin amplitude_in = 16'h3333; cfg_update = 1'b1; end
      end
      $display("shadow in RUN: amplitude=%0h", amplitude_config);
      stop = 1'b1;
      @(negedge dac_clk);
      stop = 1'b0;
      check("shadow stop busy", 32'(busy), 32'd0);
      edge_time_in = 8'h11; dc_offset_in = 16'h0123; cfg_update = 1'b1;
      @(negedge dac_clk);
      cfg_update = 1'b0;
      check("idle pend edge", 32'(edge_time_config), 32'h04);
      @(negedge dac_clk);
      check("idle xfer edge", 32'(edge_time_config), 32'h11);
      check("idle xfer off", 32'(dc_offset_config), 32'h0123);
      check("idle xfer amp", 32'(amplitude_config), 32'h3333);
      $display("shadow in IDLE: edge=%0h offset=%0h", edge_time_config, dc_offset_config);

      // start and stop together in IDLE
      start = 1'b1; stop = 1'b1;
      @(negedge dac_clk);
      start = 1'b0; stop = 1'b0;
      check("start+stop busy", 32'(busy), 32'd0);
      check("start+stop strobe", 32'(bit_strobe), 32'd0);
      @(negedge dac_clk);
      check("start+stop busy2", 32'(busy), 32'd0);

      // directed burst sequences
      run_seq(0, 2, 10, 3, 20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_seq(1, 3, 4, 2, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      run_seq(3, 0, 5, 3, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_seq(2, 1, 3, 3, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // randomized sequences with config churn and ignored starts while busy
      for (int r = 0; r < 6; r++)
         run_seq($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(1, 8),
                 $urandom_range(1, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'($urandom_range(0, 1)));

      // asynchronous reset mid-RUN
      @(negedge dac_clk);
      bit_period_cfg = 16'd2; prbs_order_cfg = 2'd2; burst_bits_cfg = '0;
      burst_count_cfg = '0; start = 1'b1;
      @(posedge dac_clk);
      @(negedge dac_clk);
      start = 1'b0;
      repeat (6) @(negedge dac_clk);
      check("pre-reset busy", 32'(busy), 32'd1);
      #2 reset_n = 1'b0;
      #1 check_reset_values("async reset");
      $display("async reset applied mid-RUN");
      @(negedge dac_clk);
      reset_n = 1'b1;
`ifdef PRBS_ERR_INJECT_EN
      check("err cnt reset", 32'(err_inject_cnt), 32'd0);
      @(negedge dac_clk);
      err_inject = 1'b1;
      @(negedge dac_clk);
      err_inject = 1'b0;
      run_seq(2, 3, 6, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("err cnt one", 32'(err_inject_cnt), 32'd1);
      run_seq(2, 2, 4, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("err cnt held", 32'(err_inject_cnt), 32'd1);
`else
      run_seq(2, 3, 6, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
